ffdiv_iter_param: RTL
=====================

Name: ffdiv_iter_param

Overview:
- Parametrised, handshaked, iterative floating-point divider. Next generation of the fixed 32-bit ffdiv top.
- Generic exponent/fraction widths, runtime rounding mode, valid/ready flow control on both sides, and an explicit FSM with a restoring mantissa divider.
- Sits between an upstream operand source and a downstream result consumer. Computes operand1 / operand2 as IEEE-754-style sign/exponent/fraction.

Parameters:
- EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1.
- FRAC_W, 23, fraction field width; operand width W = 1+EXP_W+FRAC_W.
- N_ITR, FRAC_W+3 (derived, localparam), quotient bits generated: 1 integer, FRAC_W fraction, guard, round.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/mode valid.
- in_ready  output  1  block can accept operands.
- operand1  input  W  dividend.
- operand2  input  W  divisor.
- rnd_mode  input  2  0=RNE, 1=RTZ, 2=toward +inf, 3=toward -inf.
- out_valid  output  1  result/flag valid.
- out_ready  input  1  consumer accepts result.
- result  output  W  quotient {sign, exp, frac}.
- flag  output  5  {nanf, ovf, inf, uf, zf}.
- itr_count  output  $clog2(N_ITR+1)  divide iterations performed for the current/last operation.

Behaviour:
- Reset (async, any state): FSM to IDLE; in_ready=1; out_valid=0; result=0; flag=0; itr_count=0; all internal registers cleared. No partial result survives.
- FSM states: IDLE -> DECODE -> DIVIDE -> ROUND -> DONE -> IDLE. DECODE -> DONE directly for special cases.
- IDLE: in_ready=1 only here. Accept on in_valid&&in_ready: capture operand1, operand2, rnd_mode; clear itr_count. Later input changes are ignored.
- DECODE (1 cycle):
  - Classify operands. Subnormal inputs (exp=0, frac!=0) are treated as zero.
  - sign = s1^s2.
  - Special priority: NaN operand, 0/0 or inf/inf -> qNaN {0, all-ones, 1, 0...}, nanf=1. inf/x or x/0 -> ±inf, inf=1. 0/x or x/inf -> ±0, zf=1.
  - Normal path: mantissas 1.f (FRAC_W+1 bits); signed exponent (EXP_W+2 bits) = e1 - e2 + BIAS.
- DIVIDE (exactly N_ITR cycles):
  - One restoring step per cycle: if rem >= divisor then q bit = 1 and rem -= divisor; then rem <<= 1.
  - itr_count increments each cycle, ending at N_ITR.
  - sticky = (final rem != 0).
- ROUND (1 cycle):
  - If q integer bit = 0: shift left 1, exponent -1.
  - Round using guard/round/sticky per rnd_mode. RNE uses ties-to-even. Directed modes increment the magnitude when the bits are nonzero and the sign matches the direction.
  - Mantissa carry-out -> mantissa = 1.0, exponent +1.
  - Overflow (exp >= 2^EXP_W-1): ovf=1. Result ±inf (inf=1) for RNE, or for directed rounding toward the sign's infinity. Otherwise max finite magnitude.
  - Underflow (exp <= 0): flush to ±0, uf=1, zf=1.
- DONE:
  - out_valid=1; result/flag held stable until out_ready.
  - On out_valid&&out_ready -> IDLE. out_valid drops next cycle and in_ready rises.
- Latency from accept edge to out_valid: N_ITR+3 cycles (29 at defaults) for the normal path, 2 cycles for specials.
- Throughput: one operation in flight; no accept in the same cycle as the output handshake.
- result/flag change only on entry to DONE and keep their value in IDLE.
- itr_count holds its value until the next accept. It stays 0 for specials.

Test Plan:
- 0x40C00000 / 0x40000000, RNE -> result 0x40400000, flag 00000, out_valid 29 cycles after accept, itr_count=26.
- 0x3F800000 / 0x40400000 -> RNE 0x3EAAAAAB; RTZ 0x3EAAAAAA; mode 2 0x3EAAAAAB; with operand1 = 0xBF800000 and mode 2, result 0xBEAAAAAA; all flags 00000.
- Specials:
  - 0x3F800000 / 0x00000000 -> 0x7F800000, flag 00100, latency 2.
  - 0/0 -> 0x7FC00000, flag 10000.
  - 0x40000000 / 0x7F800000 -> 0x00000000, flag 00001.
  - 0x7FC00001 / 1.0 -> 0x7FC00000, flag 10000.
- Range limits:
  - 0x7F000000 / 0x3E800000 -> RNE 0x7F800000, flag 01100; RTZ 0x7F7FFFFF, flag 01000.
  - 0x00800000 / 0x40000000 -> 0x00000000, flag 00011.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result/flag stable, in_ready=0, in_valid pulses ignored. Release -> one handshake, in_ready=1 the next cycle.
- Assert rst_n=0 at DIVIDE iteration 10 -> immediately out_valid=0, result=0, flag=0, itr_count=0, in_ready=1. A fresh 6.0/2.0 afterwards completes correctly. Repeat with EXP_W=5, FRAC_W=10: 0x4600 / 0x4000 -> 0x4200, latency 16.

Source files
------------

// File: rtl/ffdiv_iter_param.sv
// Iterative IEEE-754-style divider with generic exponent/fraction widths, runtime
// rounding mode and valid/ready handshakes; one restoring quotient bit per cycle.
module ffdiv_iter_param #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [EXP_W+FRAC_W:0]       operand1,
    input  logic [EXP_W+FRAC_W:0]       operand2,
    input  logic [1:0]                  rnd_mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [EXP_W+FRAC_W:0]       result,
    output logic [4:0]                  flag,
    output logic [$clog2(FRAC_W+4)-1:0] itr_count
);
    localparam int W     = 1 + EXP_W + FRAC_W;
    localparam int N_ITR = FRAC_W + 3;
    localparam int CW    = $clog2(N_ITR + 1);
    localparam int MW    = FRAC_W + 1;
    localparam int XW    = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS    = XW'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [XW-1:0] EXP_TOP = XW'(2 ** EXP_W - 1);
    localparam logic signed [XW-1:0] ONE_X   = XW'(1);
    localparam logic signed [XW-1:0] ZERO_X  = '0;
    localparam logic [EXP_W-1:0]     ONES    = '1;
    localparam logic [EXP_W-1:0]     EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_DIVIDE, S_ROUND, S_DONE} state_t;
    state_t state_q, state_d;

    logic [W-1:0]         op1_q, op2_q;
    logic [1:0]           mode_q;
    logic                 sign_q;
    logic signed [XW-1:0] exp_q;
    logic [MW:0]          rem_q;
    logic [MW-1:0]        dsr_q;
    logic [N_ITR-1:0]     quo_q;

    // Operand classification; subnormals fall into the zero class.
    logic               s1, s2;
    logic [EXP_W-1:0]   e1, e2;
    logic [FRAC_W-1:0]  f1, f2;
    logic               nan1, nan2, inf1, inf2, zero1, zero2;
    assign {s1, e1, f1} = op1_q;
    assign {s2, e2, f2} = op2_q;
    assign nan1  = (e1 == ONES) && (f1 != '0);
    assign nan2  = (e2 == ONES) && (f2 != '0);
    assign inf1  = (e1 == ONES) && (f1 == '0);
    assign inf2  = (e2 == ONES) && (f2 == '0);
    assign zero1 = (e1 == '0);
    assign zero2 = (e2 == '0);

    logic                 is_special;
    logic [W-1:0]         spec_result;
    logic [4:0]           spec_flag;
    logic signed [XW-1:0] exp_dec;

    // NOTE: every output of a combinational block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        is_special  = 1'b1;
        spec_result = '0;
        spec_flag   = '0;
        if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
            spec_result = {1'b0, ONES, 1'b1, {(FRAC_W-1){1'b0}}};
            spec_flag   = 5'b10000;
        end else if (inf1 || zero2) begin
            spec_result = {s1 ^ s2, ONES, {FRAC_W{1'b0}}};
            spec_flag   = 5'b00100;
        end else if (zero1 || inf2) begin
            spec_result = {s1 ^ s2, {(W-1){1'b0}}};
            spec_flag   = 5'b00001;
        end else begin
            is_special = 1'b0;
        end
    end

    assign exp_dec = $signed({2'b00, e1}) - $signed({2'b00, e2}) + BIAS;

    logic        rem_ge;
    logic [MW:0] rem_sub;
    assign rem_ge  = rem_q >= {1'b0, dsr_q};
    assign rem_sub = rem_ge ? rem_q - {1'b0, dsr_q} : rem_q;

    logic                 norm, guard, rnd, sticky, inexact, inc, carry, to_inf;
    logic [FRAC_W-1:0]    frac_t, frac_r;
    logic signed [XW-1:0] exp_n, exp_r;
    logic [W-1:0]         rnd_result;
    logic [4:0]           rnd_flag;

    // A quotient below 1.0 is renormalised by one place; guard/round come from the
    // two quotient bits below the kept fraction, sticky from the final remainder.
    always_comb begin
        norm       = quo_q[N_ITR-1];
        frac_t     = norm ? quo_q[N_ITR-2:2] : quo_q[N_ITR-3:1];
        guard      = norm ? quo_q[1] : quo_q[0];
        rnd        = norm & quo_q[0];
        sticky     = |rem_q;
        exp_n      = norm ? exp_q : exp_q - ONE_X;
        inexact    = guard | rnd | sticky;
        inc        = 1'b0;
        rnd_result = '0;
        rnd_flag   = '0;
        case (mode_q)
            2'd0:    inc = guard & (rnd | sticky | frac_t[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = inexact & ~sign_q;
            default: inc = inexact & sign_q;
        endcase
        {carry, frac_r} = {1'b0, frac_t} + {{FRAC_W{1'b0}}, inc};
        exp_r  = exp_n + (carry ? ONE_X : ZERO_X);
        to_inf = (mode_q == 2'd0) || ((mode_q == 2'd2) && !sign_q) || ((mode_q == 2'd3) && sign_q);
        if (exp_r >= EXP_TOP) begin
            rnd_result = to_inf ? {sign_q, ONES, {FRAC_W{1'b0}}} : {sign_q, EXP_MAXF, {FRAC_W{1'b1}}};
            rnd_flag   = to_inf ? 5'b01100 : 5'b01000;
        end else if (exp_r[XW-1] || (exp_r == ZERO_X)) begin
            rnd_result = {sign_q, {(W-1){1'b0}}};
            rnd_flag   = 5'b00011;
        end else begin
            rnd_result = {sign_q, exp_r[EXP_W-1:0], frac_r};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_valid) state_d = S_DECODE;
            S_DECODE: state_d = is_special ? S_DONE : S_DIVIDE;
            S_DIVIDE: if (itr_count == CW'(N_ITR - 1)) state_d = S_ROUND;
            S_ROUND:  state_d = S_DONE;
            S_DONE:   if (out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_q     <= '0;
            op2_q     <= '0;
            mode_q    <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            quo_q     <= '0;
            result    <= '0;
            flag      <= '0;
            itr_count <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    op1_q     <= operand1;
                    op2_q     <= operand2;
                    mode_q    <= rnd_mode;
                    itr_count <= '0;
                end
                S_DECODE: begin
                    sign_q <= s1 ^ s2;
                    exp_q  <= exp_dec;
                    rem_q  <= {2'b01, f1};
                    dsr_q  <= {1'b1, f2};
                    quo_q  <= '0;
                    if (is_special) begin
                        result <= spec_result;
                        flag   <= spec_flag;
                    end
                end
                S_DIVIDE: begin
                    rem_q     <= rem_sub << 1;
                    quo_q     <= {quo_q[N_ITR-2:0], rem_ge};
                    itr_count <= itr_count + CW'(1);
                end
                S_ROUND: begin
                    result <= rnd_result;
                    flag   <= rnd_flag;
                end
                default: ;
            endcase
        end
    end
endmodule
